// File: rtl/memory_stage.sv
// Memory stage of the five-stage RV32I pipeline: issues registered load/store
// requests, formats load data, and owns the M/W pipeline register.
module memory_stage #(
    parameter int D_WIDTH = 32,
    parameter int A_WIDTH = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               RegWriteM,
    input  logic [1:0]         ResultSrcM,
    input  logic               MemWriteM,
    input  logic               ATypeM,
    input  logic [D_WIDTH-1:0] ALUResultM,
    input  logic [D_WIDTH-1:0] WriteDataM,
    input  logic [A_WIDTH-1:0] RdM,
    input  logic [D_WIDTH-1:0] PCplus4M,
    output logic               StallM,
    output logic               RegWriteW,
    output logic [1:0]         ResultSrcW,
    output logic [D_WIDTH-1:0] ALUResultW,
    output logic [D_WIDTH-1:0] ReadDataW,
    output logic [A_WIDTH-1:0] RdW,
    output logic [D_WIDTH-1:0] PCplus4W,
    output logic               mem_req,
    output logic               mem_we,
    output logic [D_WIDTH-1:0] mem_addr,
    output logic [3:0]         mem_be,
    output logic [D_WIDTH-1:0] mem_wdata,
    input  logic [D_WIDTH-1:0] mem_rdata,
    input  logic               mem_ack
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUSY = 1'b1;

    logic [0:0]         state;
    logic               memop;
    logic               ack_done;
    logic               w_take;
    logic [1:0]         result_src;
    logic [D_WIDTH-1:0] load_data;

    assign memop    = MemWriteM | (ResultSrcM == 2'b01);
    assign ack_done = (state == BUSY) && mem_ack;
    assign StallM   = memop && !ack_done;
    assign w_take   = ((state == IDLE) && !memop) || ack_done;

    // Reserved encoding 11 retires as an ALU result.
    assign result_src = (ResultSrcM == 2'b11) ? 2'b00 : ResultSrcM;

    // Byte lane comes from the registered address, not the live ALU result.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        load_data = mem_rdata;
        if (ATypeM) begin
            case (mem_addr[1:0])
                2'd0:    load_data = {{(D_WIDTH-8){1'b0}}, mem_rdata[7:0]};
                2'd1:    load_data = {{(D_WIDTH-8){1'b0}}, mem_rdata[15:8]};
                2'd2:    load_data = {{(D_WIDTH-8){1'b0}}, mem_rdata[23:16]};
                default: load_data = {{(D_WIDTH-8){1'b0}}, mem_rdata[31:24]};
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_be    <= '0;
            mem_wdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (memop) begin
                        state   <= BUSY;
                        mem_req <= 1'b1;
                        mem_we  <= MemWriteM;
                        if (ATypeM) begin
                            mem_addr  <= ALUResultM;
                            mem_be    <= 4'b0001 << ALUResultM[1:0];
                            mem_wdata <= {(D_WIDTH/8){WriteDataM[7:0]}};
                        end else begin
                            mem_addr  <= {ALUResultM[D_WIDTH-1:2], 2'b00};
                            mem_be    <= 4'b1111;
                            mem_wdata <= WriteDataM;
                        end
                    end
                end
                default: begin
                    if (mem_ack) begin
                        state   <= IDLE;
                        mem_req <= 1'b0;
                    end
                end
            endcase
        end
    end

    // W register: M fields when an instruction retires, otherwise a bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            RegWriteW  <= 1'b0;
            ResultSrcW <= 2'b00;
            ALUResultW <= '0;
            ReadDataW  <= '0;
            RdW        <= '0;
            PCplus4W   <= '0;
        end else if (w_take) begin
            RegWriteW  <= RegWriteM;
            ResultSrcW <= result_src;
            ALUResultW <= ALUResultM;
            ReadDataW  <= (ack_done && !MemWriteM) ? load_data : '0;
            RdW        <= RdM;
            PCplus4W   <= PCplus4M;
        end else begin
            RegWriteW  <= 1'b0;
            ResultSrcW <= 2'b00;
            ALUResultW <= '0;
            ReadDataW  <= '0;
            RdW        <= '0;
            PCplus4W   <= '0;
        end
    end

endmodule

// File: tb/tb_memory_stage.sv
// Self-checking bench for memory_stage: vector table, memory responder with
// programmable wait states, and a W-retire scoreboard.
module tb_memory_stage;

    logic        clk;
    logic        rst_n;
    logic        RegWriteM;
    logic [1:0]  ResultSrcM;
    logic        MemWriteM;
    logic        ATypeM;
    logic [31:0] ALUResultM;
    logic [31:0] WriteDataM;
    logic [4:0]  RdM;
    logic [31:0] PCplus4M;
    logic        StallM;
    logic        RegWriteW;
    logic [1:0]  ResultSrcW;
    logic [31:0] ALUResultW;
    logic [31:0] ReadDataW;
    logic [4:0]  RdW;
    logic [31:0] PCplus4W;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    memory_stage dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .RegWriteM  (RegWriteM),
        .ResultSrcM (ResultSrcM),
        .MemWriteM  (MemWriteM),
        .ATypeM     (ATypeM),
        .ALUResultM (ALUResultM),
        .WriteDataM (WriteDataM),
        .RdM        (RdM),
        .PCplus4M   (PCplus4M),
        .StallM     (StallM),
        .RegWriteW  (RegWriteW),
        .ResultSrcW (ResultSrcW),
        .ALUResultW (ALUResultW),
        .ReadDataW  (ReadDataW),
        .RdW        (RdW),
        .PCplus4W   (PCplus4W),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_be     (mem_be),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ack    (mem_ack)
    );

    typedef struct {
        logic        rw;
        logic [1:0]  rs;
        logic        mw;
        logic        at;
        logic [31:0] alu;
        logic [31:0] wd;
        logic [4:0]  rd;
        logic [31:0] pc4;
        int          waits;
        logic [31:0] rdata;
        logic [1:0]  exp_rs;
        logic [31:0] exp_rdw;
        logic [31:0] exp_addr;
        logic [3:0]  exp_be;
        logic [31:0] exp_wdata;
    } vec_t;

    int           checks = 0;
    int           fails  = 0;
    logic [103:0] sb[$];
    bit           req_log[$];
    bit           log_en = 0;
    bit           mem_en = 1;
    int           wait_cfg = 0;
    logic [31:0]  rdata_cfg = '0;
    logic         cap_we;
    logic [31:0]  cap_addr;
    logic [3:0]   cap_be;
    logic [31:0]  cap_wdata;
    vec_t         vecs[9];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic rw, input logic [1:0] rs, input logic mw,
                                input logic at, input logic [31:0] alu, input logic [31:0] wd,
                                input logic [4:0] rd, input logic [31:0] pc4, input int waits,
                                input logic [31:0] rdata, input logic [1:0] exp_rs,
                                input logic [31:0] exp_rdw, input logic [31:0] exp_addr,
                                input logic [3:0] exp_be, input logic [31:0] exp_wdata);
        vec_t v;
        v.rw = rw; v.rs = rs; v.mw = mw; v.at = at; v.alu = alu; v.wd = wd;
        v.rd = rd; v.pc4 = pc4; v.waits = waits; v.rdata = rdata; v.exp_rs = exp_rs;
        v.exp_rdw = exp_rdw; v.exp_addr = exp_addr; v.exp_be = exp_be; v.exp_wdata = exp_wdata;
        return v;
    endfunction

    task automatic drive_nop();
        RegWriteM  = 1'b0;
        ResultSrcM = 2'b00;
        MemWriteM  = 1'b0;
        ATypeM     = 1'b0;
        ALUResultM = '0;
        WriteDataM = '0;
        RdM        = '0;
        PCplus4M   = '0;
    endtask

    // Called just after a rising edge; returns just after the edge on which the op retires.
    task automatic apply(input vec_t v);
        bit memop;
        bit done;
        int stalls;
        memop  = v.mw || (v.rs == 2'b01);
        done   = 0;
        stalls = 0;
        wait_cfg   = v.waits;
        rdata_cfg  = v.rdata;
        cap_we     = 1'bx;
        cap_addr   = 32'hFFFF_FFFF;
        cap_be     = 4'h0;
        cap_wdata  = 32'hFFFF_FFFF;
        RegWriteM  = v.rw;
        ResultSrcM = v.rs;
        MemWriteM  = v.mw;
        ATypeM     = v.at;
        ALUResultM = v.alu;
        WriteDataM = v.wd;
        RdM        = v.rd;
        PCplus4M   = v.pc4;
        sb.push_back({v.rw, v.exp_rs, v.alu, v.exp_rdw, v.rd, v.pc4});
        for (int c = 0; c < 50 && !done; c++) begin
            @(negedge clk);
            if (!StallM) done = 1;
            else stalls++;
        end
        if (!done) check("stall_timeout", 1, 0);
        @(posedge clk);
        #1;
        check("retire_latency_pc4", PCplus4W, v.pc4);
        check("stall_cycles", stalls, memop ? v.waits + 1 : 0);
        if (memop) begin
            check("mem_we", cap_we, v.mw);
            check("mem_addr", cap_addr, v.exp_addr);
            check("mem_be", cap_be, v.exp_be);
            check("mem_wdata", cap_wdata, v.exp_wdata);
        end
        drive_nop();
    endtask

    // Memory model: acks after wait_cfg BUSY cycles, captures the request it acks.
    initial begin
        int wcnt;
        wcnt      = 0;
        mem_ack   = 1'b0;
        mem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            if (!mem_en) begin
                wcnt = 0;
            end else if (mem_ack) begin
                mem_ack = 1'b0;
                wcnt    = 0;
            end else if (mem_req) begin
                if (wcnt == wait_cfg) begin
                    mem_ack   = 1'b1;
                    mem_rdata = rdata_cfg;
                    cap_we    = mem_we;
                    cap_addr  = mem_addr;
                    cap_be    = mem_be;
                    cap_wdata = mem_wdata;
                end else begin
                    wcnt++;
                end
            end
        end
    end

    // Scoreboard: a nonzero PC+4 marks a retire; anything else must be a clean bubble.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (PCplus4W != 0) begin
                if (sb.size() == 0) begin
                    check("unexpected_retire", PCplus4W, 0);
                end else begin
                    check("w_retire", {RegWriteW, ResultSrcW, ALUResultW, ReadDataW, RdW, PCplus4W},
                          sb.pop_front());
                end
            end else begin
                check("w_bubble", {RegWriteW, ResultSrcW, RdW, ALUResultW, ReadDataW}, 0);
            end
            if (log_en) req_log.push_back(mem_req);
        end
    end

    initial begin
        #2ms;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int ones;
        int first_one;
        int last_one;
        vec_t ld;
        vec_t st;

        vecs[0] = mk(1, 2'b00, 0, 0, 32'h5,         32'h0,         5'd3,  32'h1004, 0, 32'h0,
                     2'b00, 32'h0,         32'h0,     4'h0, 32'h0);
        vecs[1] = mk(1, 2'b01, 0, 0, 32'h100,       32'h1111_1111, 5'd5,  32'h1008, 0, 32'hDEAD_BEEF,
                     2'b01, 32'hDEAD_BEEF, 32'h100,   4'hF, 32'h1111_1111);
        vecs[2] = mk(0, 2'b00, 1, 1, 32'h203,       32'h1234_56AB, 5'd0,  32'h100C, 1, 32'hFFFF_FFFF,
                     2'b00, 32'h0,         32'h203,   4'h8, 32'hABAB_ABAB);
        vecs[3] = mk(1, 2'b01, 0, 1, 32'h203,       32'h0,         5'd7,  32'h1010, 0, 32'h7F00_0000,
                     2'b01, 32'h7F,        32'h203,   4'h8, 32'h0);
        vecs[4] = mk(1, 2'b01, 0, 0, 32'h302,       32'h0,         5'd9,  32'h1014, 3, 32'hCAFE_F00D,
                     2'b01, 32'hCAFE_F00D, 32'h300,   4'hF, 32'h0);
        vecs[5] = mk(1, 2'b01, 0, 1, 32'h101,       32'hC3,        5'd11, 32'h1018, 2, 32'h1234_5678,
                     2'b01, 32'h56,        32'h101,   4'h2, 32'hC3C3_C3C3);
        vecs[6] = mk(1, 2'b10, 0, 0, 32'h55,        32'h0,         5'd1,  32'h101C, 0, 32'h0,
                     2'b10, 32'h0,         32'h0,     4'h0, 32'h0);
        vecs[7] = mk(1, 2'b11, 0, 0, 32'h77,        32'h0,         5'd2,  32'h1020, 0, 32'h0,
                     2'b00, 32'h0,         32'h0,     4'h0, 32'h0);
        vecs[8] = mk(1, 2'b00, 1, 0, 32'h42,        32'hA5A5_0F0F, 5'd6,  32'h1024, 0, 32'hFFFF_FFFF,
                     2'b00, 32'h0,         32'h40,    4'hF, 32'hA5A5_0F0F);
        ld = mk(1, 2'b01, 0, 0, 32'h400, 32'h0,         5'd10, 32'h3000, 0, 32'h0BAD_CAFE,
                2'b01, 32'h0BAD_CAFE, 32'h400, 4'hF, 32'h0);
        st = mk(0, 2'b00, 1, 0, 32'h404, 32'h600D_F00D, 5'd0,  32'h3004, 0, 32'hFFFF_FFFF,
                2'b00, 32'h0,         32'h404, 4'hF, 32'h600D_F00D);

        rst_n = 1'b0;
        drive_nop();
        repeat (3) @(posedge clk);
        #1;
        check("reset_mem_port", {mem_req, mem_we, mem_be, mem_addr, mem_wdata}, 0);
        check("reset_w_reg", {RegWriteW, ResultSrcW, ALUResultW, ReadDataW, RdW, PCplus4W}, 0);
        check("reset_stall", StallM, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 9; i++) apply(vecs[i]);

        // Back-to-back load then store: two request pulses separated by one low cycle.
        req_log.delete();
        log_en = 1;
        apply(ld);
        apply(st);
        @(negedge clk);
        #1;
        log_en    = 0;
        ones      = 0;
        first_one = -1;
        last_one  = -1;
        foreach (req_log[i]) begin
            if (req_log[i]) begin
                ones++;
                if (first_one < 0) first_one = i;
                last_one = i;
            end
        end
        check("b2b_req_cycles", ones, 2);
        check("b2b_req_gap", last_one - first_one, 2);

        // Reset while BUSY: request abandoned, stray ack afterwards ignored.
        @(posedge clk);
        #1;
        mem_en     = 0;
        RegWriteM  = 1'b1;
        ResultSrcM = 2'b01;
        ALUResultM = 32'h80;
        RdM        = 5'd4;
        PCplus4M   = 32'h2000;
        @(posedge clk);
        #1;
        check("abort_req_issued", mem_req, 1);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort_req_dropped", mem_req, 0);
        drive_nop();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        mem_ack   = 1'b1;
        mem_rdata = 32'h5555_AAAA;
        @(posedge clk);
        #1;
        mem_ack = 1'b0;
        check("stray_ack_req", mem_req, 0);
        check("stray_ack_w", {RegWriteW, RdW, PCplus4W}, 0);
        repeat (2) @(posedge clk);
        #1;
        check("stray_ack_idle", {mem_req, StallM}, 0);
        mem_en = 1;
        apply(mk(1, 2'b00, 0, 0, 32'h9, 32'h0, 5'd8, 32'h2004, 0, 32'h0,
                 2'b00, 32'h0, 32'h0, 4'h0, 32'h0));

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule

// File: doc/memory_stage.md
# memory_stage

Memory stage of the five-stage RV32I pipeline, directly downstream of the execute stage. It consumes the execute-to-memory register outputs, performs load/store accesses through a registered request/acknowledge data-memory port, and owns the memory-to-writeback pipeline register. It stalls the front of the pipeline with `StallM` while an access is outstanding.

## Interface
- `D_WIDTH`, 32, data/address width
- `A_WIDTH`, 5, register-index width

Ports:
- `clk`  in  1  clock; all state updates on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `RegWriteM`  in  1  register write enable of instruction in M
- `ResultSrcM`  in  2  result select: 00 ALU, 01 load data, 10 PC+4, 11 reserved (treated as 00, no access)
- `MemWriteM`  in  1  store enable
- `ATypeM`  in  1  access size: 1 byte, 0 word
- `ALUResultM`  in  D_WIDTH  effective address / ALU result
- `WriteDataM`  in  D_WIDTH  store data
- `RdM`  in  A_WIDTH  destination register
- `PCplus4M`  in  D_WIDTH  PC+4 of instruction in M
- `StallM`  out  1  freeze F/D/E and the E/M register this cycle
- `RegWriteW`, `ResultSrcW`, `ALUResultW`, `ReadDataW`, `RdW`, `PCplus4W`  out  as M counterparts  writeback register
- `mem_req`  out  1  access request (registered)
- `mem_we`  out  1  1 store, 0 load (registered)
- `mem_addr`  out  D_WIDTH  byte address; low two bits forced 0 for word access (registered)
- `mem_be`  out  4  byte enables (registered)
- `mem_wdata`  out  D_WIDTH  store data (registered)
- `mem_rdata`  in  D_WIDTH  load data, valid with `mem_ack`
- `mem_ack`  in  1  access complete; one-cycle pulse

## Operation
- memop = `MemWriteM` | (`ResultSrcM`==01). Non-memop instructions pass to W in one cycle, no stall.
- FSM states IDLE, BUSY.
  - IDLE, memop: register `mem_req`=1, `mem_we`=`MemWriteM`, address, enables, data; go BUSY. W register loads bubble.
  - IDLE, no memop: W register loads the M fields; `ReadDataW`=0.
  - BUSY, `mem_ack`=0: hold all port outputs; W register loads bubble.
  - BUSY, `mem_ack`=1: W register loads M fields plus formatted read data; `mem_req`<=0; go IDLE.
- `mem_ack` in IDLE ignored.
- `StallM` = memop & ~(state==BUSY & `mem_ack`); combinational.
- Bubble: `RegWriteW`=0, `ResultSrcW`=00, `RdW`=0, data fields 0.
- Upstream holds all M inputs stable while `StallM`=1.
- Word: `mem_be`=1111, `mem_wdata`=`WriteDataM`, `ReadDataW`=`mem_rdata`.
- Byte: `mem_be`=0001 << addr[1:0], `mem_wdata`={4{WriteDataM[7:0]}}, `ReadDataW`= zero-extended `mem_rdata` lane addr[1:0] (lane taken from registered `mem_addr`).
- Stores: `ReadDataW`=0; `RegWriteW` copies `RegWriteM` unchanged.

## Timing
- Reset (async assert, sync effect on release): state IDLE, all W outputs 0, `mem_req`=`mem_we`=0, `mem_addr`=`mem_wdata`=0, `mem_be`=0.
- Non-memop: presented cycle n, W valid cycle n+1.
- Memop, ack at first BUSY cycle: presented n, `mem_req` high n+1, W valid n+2; `StallM` high in cycle n only.
- Each extra wait cycle adds one cycle to `StallM` and W latency; bubbles fill W meanwhile.
- Back-to-back memops: second op samples IDLE the cycle after ack; `mem_req` drops for exactly one cycle between them.
- Reset asserted in BUSY: request abandoned, `mem_req` low immediately; a later stray `mem_ack` is ignored.

## Test plan
- Reset, then ADD result 0x0000_0005 to x3 -> next cycle `RegWriteW`=1, `RdW`=3, `ALUResultW`=5, `StallM` never high.
- Word load addr 0x100, memory acks first BUSY cycle with 0xDEAD_BEEF -> `mem_be`=1111, `StallM` one cycle, `ReadDataW`=0xDEAD_BEEF two cycles after issue.
- Byte store 0x1234_56AB to 0x203 -> `mem_be`=1000, `mem_wdata`=0xABAB_ABAB, `mem_we`=1; byte load 0x203 with rdata 0x7F00_0000 -> `ReadDataW`=0x0000_007F.
- Load with three wait cycles -> `StallM` high four cycles, `RegWriteW`=0 bubbles throughout, single W write of load data.
- Load followed immediately by store -> `mem_req` pulses separately with one low cycle between, each op retires once.
- Assert `rst_n`=0 mid-BUSY, ack arrives after release -> `mem_req`=0, state IDLE, no W write.
